// File: rtl/i2c_master_seq.sv
// Byte-level I2C master sequencer: one START/STOP/WRITE/READ command in, one response out.
// Bus timing comes from a quarter-bit divider with SCL stretching and arbitration-loss abort.
module i2c_master_seq #(
    parameter int unsigned CLK_DIV        = 4,
    parameter int unsigned I2C_DATA_WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [I2C_DATA_WIDTH-1:0] cmd_data,
    output logic                      rsp_valid,
    output logic [I2C_DATA_WIDTH-1:0] rsp_data,
    output logic                      rsp_ack,
    output logic                      rsp_err,
    output logic                      rsp_arb_lost,
    output logic                      bus_owned,
    input  logic                      scl_i,
    input  logic                      sda_i,
    output logic                      scl_oe,
    output logic                      sda_oe
);
    localparam int unsigned W  = I2C_DATA_WIDTH;
    localparam int unsigned BW = $clog2(W + 1);
    localparam logic [9:0]  Q_TC = 10'(CLK_DIV - 1);

    localparam logic [2:0] OP_START    = 3'd0;
    localparam logic [2:0] OP_STOP     = 3'd1;
    localparam logic [2:0] OP_WRITE    = 3'd2;
    localparam logic [2:0] OP_READ_ACK = 3'd3;
    localparam logic [2:0] OP_READ_NAK = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RSP} state_t;

    state_t         state, state_nx;
    logic [9:0]     qcnt;
    logic [1:0]     quarter;
    logic [BW-1:0]  bit_idx;
    logic [2:0]     op_q;
    logic [W-1:0]   shreg;
    logic           pend, alive, sda_s;
    logic           is_write, is_read, last_bit, reject;
    logic           cnt_en, q_tc, sample, phase_end, master_bit, sda_drive, arb_loss;

    assign is_write   = (op_q == OP_WRITE);
    assign is_read    = (op_q == OP_READ_ACK) || (op_q == OP_READ_NAK);
    assign last_bit   = (bit_idx == BW'(W));
    assign reject     = !((op_q == OP_START) ||
                          (bus_owned && ((op_q == OP_STOP) || is_write || is_read)));
    // Q2 is held while a slave keeps SCL low
    assign cnt_en     = !((quarter == 2'd2) && !scl_i);
    assign q_tc       = cnt_en && (qcnt == Q_TC);
    assign sample     = (state == S_BIT) && (quarter == 2'd2) && q_tc;
    assign phase_end  = (quarter == 2'd3) && q_tc;
    assign sda_drive  = is_write ? (!last_bit && !shreg[W-1])
                                 : (is_read && last_bit && (op_q == OP_READ_ACK));
    assign master_bit = is_write ? !last_bit : (last_bit && (op_q == OP_READ_NAK));
    assign arb_loss   = sample && master_bit && !sda_drive && !sda_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    if (reject)                 state_nx = S_RSP;
                    else if (op_q == OP_START)  state_nx = S_START;
                    else if (op_q == OP_STOP)   state_nx = S_STOP;
                    else                        state_nx = S_BIT;
                end
            end
            S_START, S_STOP: if (phase_end) state_nx = S_RSP;
            S_BIT:   if (arb_loss || (phase_end && last_bit)) state_nx = S_RSP;
            S_RSP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == S_IDLE) && !pend && alive;
        rsp_valid = (state == S_RSP);
        scl_oe    = bus_owned;
        sda_oe    = 1'b0;
        case (state)
            S_START: begin
                case (quarter)
                    2'd0:    begin scl_oe = bus_owned; sda_oe = 1'b0; end
                    2'd1:    begin scl_oe = 1'b0;      sda_oe = 1'b0; end
                    2'd2:    begin scl_oe = 1'b0;      sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b1;      sda_oe = 1'b1; end
                endcase
            end
            S_STOP: begin
                case (quarter)
                    2'd0:    begin scl_oe = 1'b1; sda_oe = 1'b1; end
                    2'd1:    begin scl_oe = 1'b0; sda_oe = 1'b1; end
                    default: begin scl_oe = 1'b0; sda_oe = 1'b0; end
                endcase
            end
            S_BIT: begin
                scl_oe = (quarter < 2'd2);
                sda_oe = sda_drive;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend         <= 1'b0;
            alive        <= 1'b0;
            op_q         <= '0;
            shreg        <= '0;
            qcnt         <= '0;
            quarter      <= '0;
            bit_idx      <= '0;
            sda_s        <= 1'b0;
            bus_owned    <= 1'b0;
            rsp_data     <= '0;
            rsp_ack      <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_arb_lost <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (cmd_valid && cmd_ready) begin
                pend  <= 1'b1;
                op_q  <= cmd_op;
                shreg <= cmd_data;
            end
            if ((state == S_IDLE) && pend) begin
                pend    <= 1'b0;
                qcnt    <= '0;
                quarter <= '0;
                bit_idx <= '0;
                if (reject) begin
                    rsp_err      <= 1'b1;
                    rsp_arb_lost <= 1'b0;
                    rsp_ack      <= 1'b0;
                    rsp_data     <= '0;
                end
            end
            if (state inside {S_START, S_STOP, S_BIT}) begin
                if (q_tc) begin
                    qcnt    <= '0;
                    quarter <= quarter + 2'd1;
                end else if (cnt_en) begin
                    qcnt <= qcnt + 10'd1;
                end
                if (sample) sda_s <= sda_i;
                // one register serves as TX source and RX sink; TX bit shifts out as RX bit shifts in
                if ((state == S_BIT) && phase_end && !last_bit) begin
                    bit_idx <= bit_idx + BW'(1);
                    shreg   <= {shreg[W-2:0], sda_s};
                end
                if (arb_loss) begin
                    bus_owned    <= 1'b0;
                    rsp_err      <= 1'b1;
                    rsp_arb_lost <= 1'b1;
                    rsp_ack      <= 1'b0;
                    rsp_data     <= '0;
                end else if (phase_end && ((state != S_BIT) || last_bit)) begin
                    rsp_err      <= 1'b0;
                    rsp_arb_lost <= 1'b0;
                    rsp_ack      <= (state == S_BIT) && is_write && !sda_s;
                    rsp_data     <= ((state == S_BIT) && is_read) ? shreg : '0;
                    if (state == S_START) bus_owned <= 1'b1;
                    if (state == S_STOP)  bus_owned <= 1'b0;
                end
            end
        end
    end
endmodule
